// File: rtl/qpsk_bit_packer_pkg.sv
// Shared definitions for the QPSK bit packer: FSM/source encodings,
// idle symbol default and Gray <-> phase-index helpers.
package qpsk_bit_packer_pkg;

  localparam logic [1:0]  IDLE_SYM_DEF    = 2'b00;
  localparam int unsigned DIBITS_PER_BYTE = 32'd4;

  // Gray-coded QPSK constellation points listed by phase index 0..3
  localparam logic [1:0] QPSK_PH0 = 2'b00;
  localparam logic [1:0] QPSK_PH1 = 2'b01;
  localparam logic [1:0] QPSK_PH2 = 2'b11;
  localparam logic [1:0] QPSK_PH3 = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Where the next dibit comes from at a symbol boundary
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_SHIFT = 2'd1,
    SRC_BUF   = 2'd2,
    SRC_BYP   = 2'd3
  } src_t;

  // Gray dibit -> phase index
  function automatic logic [1:0] g2b(input logic [1:0] g);
    case (g)
      QPSK_PH0: g2b = 2'd0;
      QPSK_PH1: g2b = 2'd1;
      QPSK_PH2: g2b = 2'd2;
      QPSK_PH3: g2b = 2'd3;
      default:  g2b = 2'd0;
    endcase
  endfunction

  // Phase index -> Gray dibit
  function automatic logic [1:0] b2g(input logic [1:0] b);
    case (b)
      2'd0:    b2g = QPSK_PH0;
      2'd1:    b2g = QPSK_PH1;
      2'd2:    b2g = QPSK_PH2;
      2'd3:    b2g = QPSK_PH3;
      default: b2g = QPSK_PH0;
    endcase
  endfunction

endpackage

// File: rtl/qpsk_bit_packer_if.sv
// Byte-in / symbol-out bus of the QPSK bit packer.
// master = upstream byte source, slave = the packer itself.
interface qpsk_bit_packer_if;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       byte_last_i;
  logic       byte_ready_o;
  logic [1:0] sym_o;
  logic       sym_valid_o;
  logic       sym_strobe_o;
  logic       underrun_o;

  modport master (
    output byte_i, byte_valid_i, byte_last_i,
    input  byte_ready_o, sym_o, sym_valid_o, sym_strobe_o, underrun_o
  );

  modport slave (
    input  byte_i, byte_valid_i, byte_last_i,
    output byte_ready_o, sym_o, sym_valid_o, sym_strobe_o, underrun_o
  );
endinterface

// File: rtl/qpsk_bit_packer_symbol_timer.sv
// Symbol timer: counts 0..SPS-1 while enabled, flags the last clock of a symbol.
module qpsk_symbol_timer #(
  parameter int unsigned SPS = 32'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bnd
);

  localparam int unsigned    CW   = (SPS > 32'd1) ? $clog2(SPS) : 32'd1;
  localparam logic [CW-1:0]  LAST = CW'(SPS - 32'd1);

  logic [CW-1:0] r_cnt;

  // Per-symbol clock counter, wraps at the symbol boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_en) begin
      if (r_cnt == LAST) begin
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_bnd = (r_cnt == LAST);

endmodule

// File: rtl/qpsk_bit_packer.sv
// QPSK bit packer: takes bytes over valid/ready, emits dibits MSB pair first,
// each held SPS clocks, with optional differential phase encoding.
module qpsk_bit_packer
  import qpsk_bit_packer_pkg::*;
#(
  parameter int unsigned SPS      = 32'd4,
  parameter bit          DIFF_EN  = 1'b0,
  parameter logic [1:0]  IDLE_SYM = IDLE_SYM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  qpsk_bit_packer_if.slave  bus
);

  state_t     r_state;
  logic       r_first;     // first clock in RUN: present a dibit immediately
  logic [7:0] r_shift;
  logic [2:0] r_dib_cnt;   // dibits of r_shift not yet presented
  logic       r_act_last;  // last flag of the byte in r_shift
  logic [7:0] r_buf;
  logic       r_buf_full;
  logic       r_buf_last;
  logic [1:0] r_acc;
  logic       r_ready;
  logic [1:0] r_sym;
  logic       r_sym_valid;
  logic       r_sym_strobe;
  logic       r_underrun;

  logic       w_bnd;
  logic       w_accept;
  logic       w_advance;
  src_t       w_src;
  logic [1:0] w_dibit;
  logic [1:0] w_acc_nxt;
  logic [1:0] w_sym;
  logic       w_buf_load;
  logic       w_buf_full_nxt;
  logic       w_tmr_en;
  logic       w_tmr_clr;

  assign w_tmr_en  = (r_state == ST_RUN);
  assign w_tmr_clr = (r_state != ST_RUN) | r_first;

  qpsk_symbol_timer #(.SPS(SPS)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_tmr_en),
    .i_clr (w_tmr_clr),
    .o_bnd (w_bnd)
  );

  // Handshake, next-dibit source selection, encoding and buffer occupancy
  always_comb begin
    w_accept  = bus.byte_valid_i & r_ready;
    w_advance = (r_state == ST_RUN) & (r_first | w_bnd);
    w_src     = SRC_NONE;
    if (w_advance) begin
      if (r_dib_cnt != 3'd0) begin
        w_src = SRC_SHIFT;
      end else if (r_buf_full) begin
        w_src = SRC_BUF;
      end else if (w_accept) begin
        w_src = SRC_BYP;
      end else begin
        w_src = SRC_NONE;
      end
    end else begin
      w_src = SRC_NONE;
    end

    case (w_src)
      SRC_SHIFT: w_dibit = r_shift[7:6];
      SRC_BUF:   w_dibit = r_buf[7:6];
      SRC_BYP:   w_dibit = bus.byte_i[7:6];
      default:   w_dibit = 2'b00;
    endcase

    w_acc_nxt = r_acc + g2b(w_dibit);
    if (DIFF_EN) begin
      w_sym = b2g(w_acc_nxt);
    end else begin
      w_sym = w_dibit;
    end

    // A byte accepted while running parks in the buffer unless it bypasses
    w_buf_load = w_accept & (r_state == ST_RUN) & (w_src != SRC_BYP);
    if (w_buf_load) begin
      w_buf_full_nxt = 1'b1;
    end else if (w_src == SRC_BUF) begin
      w_buf_full_nxt = 1'b0;
    end else begin
      w_buf_full_nxt = r_buf_full;
    end
  end

  // FSM, byte storage and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_first      <= 1'b0;
      r_shift      <= 8'h00;
      r_dib_cnt    <= 3'd0;
      r_act_last   <= 1'b0;
      r_buf        <= 8'h00;
      r_buf_full   <= 1'b0;
      r_buf_last   <= 1'b0;
      r_acc        <= 2'd0;
      r_ready      <= 1'b0;
      r_sym        <= IDLE_SYM;
      r_sym_valid  <= 1'b0;
      r_sym_strobe <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_ready      <= ~w_buf_full_nxt;
      r_buf_full   <= w_buf_full_nxt;
      r_sym_strobe <= 1'b0;
      if (w_buf_load) begin
        r_buf      <= bus.byte_i;
        r_buf_last <= bus.byte_last_i;
      end
      case (r_state)
        ST_IDLE: begin
          r_sym       <= IDLE_SYM;
          r_sym_valid <= 1'b0;
          if (w_accept) begin
            r_shift    <= bus.byte_i;
            r_dib_cnt  <= 3'(DIBITS_PER_BYTE);
            r_act_last <= bus.byte_last_i;
            r_first    <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_advance) begin
            r_first <= 1'b0;
            case (w_src)
              SRC_SHIFT: begin
                r_shift   <= {r_shift[5:0], 2'b00};
                r_dib_cnt <= r_dib_cnt - 3'd1;
              end
              SRC_BUF: begin
                r_shift    <= {r_buf[5:0], 2'b00};
                r_dib_cnt  <= 3'(DIBITS_PER_BYTE - 32'd1);
                r_act_last <= r_buf_last;
              end
              SRC_BYP: begin
                r_shift    <= {bus.byte_i[5:0], 2'b00};
                r_dib_cnt  <= 3'(DIBITS_PER_BYTE - 32'd1);
                r_act_last <= bus.byte_last_i;
              end
              default: begin
                // Starved: clean end if the final byte closed the burst
                r_state    <= ST_IDLE;
                r_underrun <= r_underrun | ~r_act_last;
              end
            endcase
            if (w_src != SRC_NONE) begin
              r_sym        <= w_sym;
              r_sym_valid  <= 1'b1;
              r_sym_strobe <= 1'b1;
              r_acc        <= w_acc_nxt;
            end else begin
              r_sym        <= IDLE_SYM;
              r_sym_valid  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.byte_ready_o = r_ready;
  assign bus.sym_o        = r_sym;
  assign bus.sym_valid_o  = r_sym_valid;
  assign bus.sym_strobe_o = r_sym_strobe;
  assign bus.underrun_o   = r_underrun;

endmodule

// File: tb/tb_qpsk_bit_packer.sv
// Self-checking bench: three packer instances (SPS=4 plain, SPS=2 differential,
// SPS=1 plain) driven with directed and random bursts, checked against a
// byte-level reference model.
module tb_qpsk_bit_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qpsk_bit_packer_if bus_a();
  qpsk_bit_packer_if bus_b();
  qpsk_bit_packer_if bus_c();

  qpsk_bit_packer #(.SPS(4), .DIFF_EN(1'b0), .IDLE_SYM(2'b00)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  qpsk_bit_packer #(.SPS(2), .DIFF_EN(1'b1), .IDLE_SYM(2'b00)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
  qpsk_bit_packer #(.SPS(1), .DIFF_EN(1'b0), .IDLE_SYM(2'b00)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

  int SPSV[3] = '{4, 2, 1};
  bit DIFV[3] = '{1'b0, 1'b1, 1'b0};
  int G2I[4]  = '{0, 1, 3, 2};   // indexed by dibit value: 00,01,10,11
  int I2G[4]  = '{0, 1, 3, 2};   // phase index -> dibit value

  logic [1:0] o_sym[3];
  logic       o_val[3], o_stb[3], o_und[3], o_rdy[3];
  assign o_sym[0] = bus_a.sym_o;  assign o_val[0] = bus_a.sym_valid_o;
  assign o_stb[0] = bus_a.sym_strobe_o; assign o_und[0] = bus_a.underrun_o;
  assign o_rdy[0] = bus_a.byte_ready_o;
  assign o_sym[1] = bus_b.sym_o;  assign o_val[1] = bus_b.sym_valid_o;
  assign o_stb[1] = bus_b.sym_strobe_o; assign o_und[1] = bus_b.underrun_o;
  assign o_rdy[1] = bus_b.byte_ready_o;
  assign o_sym[2] = bus_c.sym_o;  assign o_val[2] = bus_c.sym_valid_o;
  assign o_stb[2] = bus_c.sym_strobe_o; assign o_und[2] = bus_c.underrun_o;
  assign o_rdy[2] = bus_c.byte_ready_o;

  // Monitor log (written only by the monitor)
  logic [1:0] sbuf[3][512];
  int scnt[3]     = '{0, 0, 0};
  int vcnt[3]     = '{0, 0, 0};
  int rises[3]    = '{0, 0, 0};
  int hold_err[3] = '{0, 0, 0};
  int gap_err[3]  = '{0, 0, 0};
  int since[3]    = '{0, 0, 0};
  logic       pval[3] = '{1'b0, 1'b0, 1'b0};
  logic [1:0] cur[3]  = '{2'b00, 2'b00, 2'b00};

  // Sample outputs on the falling edge, log strobed symbols and timing anomalies
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (o_val[d]) begin
        vcnt[d]++;
        if (!pval[d]) rises[d]++;
        if (o_stb[d]) begin
          if (pval[d] && since[d] != SPSV[d]) gap_err[d]++;
          since[d] = 0;
          if (scnt[d] < 512) sbuf[d][scnt[d]] = o_sym[d];
          scnt[d]++;
          cur[d] = o_sym[d];
        end else if (o_sym[d] != cur[d] || !pval[d]) begin
          hold_err[d]++;
        end
      end else if (o_stb[d] || o_sym[d] != 2'b00) begin
        hold_err[d]++;
      end
      since[d]++;
      pval[d] = o_val[d];
    end
  end

  int ntests = 0;
  int nfail  = 0;
  int macc[3] = '{0, 0, 0};
  logic [7:0] tx[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] b, input logic l);
    case (d)
      0: begin bus_a.byte_valid_i = v; bus_a.byte_i = b; bus_a.byte_last_i = l; end
      1: begin bus_b.byte_valid_i = v; bus_b.byte_i = b; bus_b.byte_last_i = l; end
      default: begin bus_c.byte_valid_i = v; bus_c.byte_i = b; bus_c.byte_last_i = l; end
    endcase
  endtask

  // Present one byte and hold it until the accepting edge has passed
  task automatic send(input int d, input logic [7:0] b, input logic l);
    int w;
    w = 0;
    drive(d, 1'b1, b, l);
    while (!o_rdy[d] && w < 200) begin
      tick();
      w++;
    end
    chk("ready_wait", (w < 200), 1);
    tick();
  endtask

  // Send tx[0..n-1] back to back, then compare everything against the model
  task automatic burst(input int d, input int n, input bit with_last, input logic exp_und);
    int bs, bv, br, bh, bg, e, dib;
    bs = scnt[d]; bv = vcnt[d]; br = rises[d]; bh = hold_err[d]; bg = gap_err[d];
    for (int i = 0; i < n; i++) send(d, tx[i], with_last && (i == n - 1));
    drive(d, 1'b0, 8'h00, 1'b0);
    repeat (4 * SPSV[d] * n + 8) tick();
    chk("sym_count", scnt[d] - bs, 4 * n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        dib = (int'(tx[i]) >> (6 - 2 * k)) % 4;
        if (DIFV[d]) begin
          macc[d] = (macc[d] + G2I[dib]) % 4;
          e = I2G[macc[d]];
        end else begin
          e = dib;
        end
        chk("sym", sbuf[d][(bs + 4 * i + k) % 512], e);
      end
    end
    chk("valid_clks", vcnt[d] - bv, 4 * n * SPSV[d]);
    chk("contiguous", rises[d] - br, 1);
    chk("hold", hold_err[d] - bh, 0);
    chk("strobe_gap", gap_err[d] - bg, 0);
    chk("valid_end", o_val[d], 1'b0);
    chk("underrun", o_und[d], exp_und);
  endtask

  logic [1:0] e2[4]  = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] e3[8]  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
  logic [1:0] e5[4]  = '{2'b01, 2'b11, 2'b10, 2'b00};

  initial begin
    int bs;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00, 1'b0);

    // Reset values
    tick(); tick();
    chk("rst_ready", o_rdy[0], 1'b0);
    chk("rst_sym", o_sym[0], 2'b00);
    chk("rst_valid", o_val[0], 1'b0);
    chk("rst_strobe", o_stb[0], 1'b0);
    chk("rst_underrun", o_und[0], 1'b0);
    rst = 1'b0;
    chk("ready_pre_edge", o_rdy[0], 1'b0);
    tick();
    chk("ready_after_release", o_rdy[0], 1'b1);
    chk("ready_after_release_c", o_rdy[2], 1'b1);

    // 0xB4 with last on SPS=4
    tx[0] = 8'hB4;
    bs = scnt[0];
    burst(0, 1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk("b4_sym", sbuf[0][bs + i], e2[i]);

    // 0x1B, 0xE4 back to back
    tx[0] = 8'h1B; tx[1] = 8'hE4;
    bs = scnt[0];
    burst(0, 2, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) chk("pair_sym", sbuf[0][bs + i], e3[i]);

    // Differential, SPS=2: 0x55 then 0x00
    tx[0] = 8'h55;
    bs = scnt[1];
    burst(1, 1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk("diff55_sym", sbuf[1][bs + i], e5[i]);
    tx[0] = 8'h00;
    bs = scnt[1];
    burst(1, 1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk("diff00_sym", sbuf[1][bs + i], 2'b00);

    // SPS=1: three bytes streamed with valid held high
    for (int i = 0; i < 3; i++) tx[i] = 8'($urandom_range(0, 255));
    burst(2, 3, 1'b1, 1'b0);

    // Random bursts on every instance
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 3; d++) begin
        int n;
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) tx[i] = 8'($urandom_range(0, 255));
        burst(d, n, 1'b1, 1'b0);
      end
    end

    // Underrun: single byte without last
    tx[0] = 8'h00;
    burst(0, 1, 1'b0, 1'b1);
    repeat (20) tick();
    chk("underrun_sticky", o_und[0], 1'b1);

    // First-symbol latency, then reset mid-symbol
    send(0, 8'hC3, 1'b1);
    drive(0, 1'b0, 8'h00, 1'b0);
    chk("lat_valid_pre", o_val[0], 1'b0);
    tick();
    chk("lat_valid", o_val[0], 1'b1);
    chk("lat_strobe", o_stb[0], 1'b1);
    chk("lat_sym", o_sym[0], 2'b11);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", o_rdy[0], 1'b0);
    chk("midrst_sym", o_sym[0], 2'b00);
    chk("midrst_valid", o_val[0], 1'b0);
    chk("midrst_strobe", o_stb[0], 1'b0);
    chk("midrst_underrun", o_und[0], 1'b0);
    for (int d = 0; d < 3; d++) macc[d] = 0;
    tick();
    rst = 1'b0;
    tick();
    chk("ready_after_midrst", o_rdy[0], 1'b1);

    // Differential accumulator restarts from zero after reset
    tx[0] = 8'h55;
    bs = scnt[1];
    burst(1, 1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) chk("diff_after_rst", sbuf[1][bs + i], e5[i]);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
